rv_dmem: RTL
============

# rv_dmem

Data-memory responder for the `rv_core` data bus. It serves the core's `d_*` requests from a byte-lane-writable synchronous SRAM with a parameterised number of read wait states. It drives `d_rdy` to stall the core pipeline during waits, and returns zero read data outside its window so the core's internal MTIME/MTIMECMP read path, which ORs onto `d_dr`, stays clean. It sits between `rv_core` and the top level, one instance per core.

## Interface
- `AWIDTH`, 14: byte-address bits of the SRAM window (2^AWIDTH bytes, word-organised).
- `BASE`, 32'h0000_0000: window base address; must be 2^AWIDTH aligned.
- `WAIT`, 0: read wait states (0..15).
- `BIG_ENDIAN`, 0: value driven on `d_be`.
- `clk`  in  1  single clock, rising edge.
- `xreset`  in  1  reset; asynchronous, active-low.
- `d_adr`  in  32  byte address from core.
- `d_re`  in  1  read request.
- `d_dw`  in  32  write data, already lane-aligned by core.
- `d_we`  in  4  byte-lane write enables.
- `d_dr`  out  32  read data.
- `d_rdy`  out  1  bus ready; low stalls the core.
- `d_be`  out  1  bus endianness, constant `BIG_ENDIAN`.
- `err_cnt`  out  16  out-of-window access count.
- `err_adr`  out  32  last out-of-window address.

## Operation
- Hit: `d_adr[31:AWIDTH] == BASE[31:AWIDTH]`. The word index is `d_adr[AWIDTH-1:2]`. `d_adr[1:0]` is ignored because lane selection is done by the core.
- Acceptance: a request is accepted on a rising edge where `d_rdy`=1 and (`d_re`=1 or `d_we`!=0). While `d_rdy`=0 the bus inputs are ignored; the core holds them.
- Write, hit: the lanes set in `d_we` are written at the acceptance edge. Writes are posted and have no wait states.
- Write, miss: dropped.
- `d_re`=1 with `d_we`!=0 in the same request: the write is performed and the read is ignored.
- Read: the SRAM is read at the acceptance edge. On a miss, the returned data is 0.
- State machine `IDLE`, `WAITS`, `DATA`:
  - `IDLE`: `d_rdy`=1, `d_dr`=0. On accepting a read, go to `DATA` if `WAIT`=0, otherwise go to `WAITS` with the counter loaded to `WAIT`-1.
  - `WAITS`: `d_rdy`=0, `d_dr`=0. Decrement the counter; go to `DATA` when it reaches 0.
  - `DATA`: `d_rdy`=1, `d_dr`=read word. If a new read is accepted in this cycle, take the same transition as from `IDLE`; otherwise return to `IDLE`. A write accepted here is performed and the state returns to `IDLE`.
- `d_dr` is 0 in every cycle that is not `DATA`. This is mandatory because the core ORs `d_dr` with its internal timer read data.
- Read-after-write to the same word on consecutive requests returns the new data.

## Timing
- Reset values: `d_rdy`=1, `d_dr`=0, `err_cnt`=0, `err_adr`=0, state `IDLE`, counter 0. SRAM contents are not cleared.
- Read latency: data is valid on `d_dr` with `d_rdy`=1 exactly `WAIT`+1 cycles after acceptance. `d_rdy` is low for exactly `WAIT` cycles per read.
- Back-to-back reads with `WAIT`=0 sustain one per cycle. With `WAIT`=n, the rate is one per n+1 cycles.
- Write: 1 cycle, never deasserts `d_rdy`.
- Reset asserted mid-`WAITS`: immediate return to `IDLE` with `d_rdy`=1. The pending read is lost.
- The counter never wraps; `WAIT`>15 is a parameter error, checked by an elaboration assertion.

## Configuration
- `RV_DMEM_ERRCNT_EN` defined:
  - Each accepted miss (read or write) increments `err_cnt`, saturating at 16'hFFFF.
  - `err_adr` captures `d_adr` of that access.
  - Misses inside 0xffff8000–0xffff800f (core timer) are not counted.
- Not defined: `err_cnt` and `err_adr` are tied to 0 and no counter logic is built. Bus behaviour is identical.

## Structure
- `pkg_rv_dmem`: `dmem_state_t` enum (`IDLE`, `WAITS`, `DATA`), the timer-region constants `MTIME_LO`/`MTIME_HI`, and `WAIT_MAX`=15.
- Sub-module `rv_dmem_ram`: single-port synchronous RAM, 2^(AWIDTH-2) x 32, four byte-lane write enables, registered read output, optional `$readmemh` init file parameter.
- The FSM, hit decode and error logic live in `rv_dmem`.

## Test plan
- Reset, `WAIT`=0: write 0xDEADBEEF to 0x100 with `d_we`=4'hF, then read 0x100 -> `d_dr`=0xDEADBEEF one cycle after acceptance, `d_rdy` never low.
- Byte lanes: write 0x11223344, then write 0x000000AA with `d_we`=4'b0001, then read -> 0x112233AA. Repeat with `d_we`=4'b1100 and data 0x55660000 -> 0x556633AA.
- `WAIT`=3: read 0x40 -> `d_rdy` low for exactly 3 cycles, `d_dr`=0 during the stall, data valid on cycle 4 together with `d_rdy`=1. A back-to-back second read starts its stall immediately.
- Miss: read 0xffff8000 and 0x8000_0000 -> `d_dr`=0 at the normal latency. With `RV_DMEM_ERRCNT_EN`: `err_cnt`=1 and `err_adr`=0x8000_0000 (timer address not counted). Write to a miss address leaves SRAM unchanged.
- Reset asserted during `WAITS` (`WAIT`=5, cycle 2) -> `d_rdy`=1 and `d_dr`=0 asynchronously. After release, a new read behaves normally and previously written SRAM data is intact.
- Simultaneous `d_re`=1 and `d_we`=4'hF to 0x20 -> the write is applied, `d_dr` stays 0, and the next read of 0x20 returns the written value.

Source files
------------

// File: rtl/rv_dmem_pkg.sv
// Shared types and constants for the rv_core data-memory responder.
package pkg_rv_dmem;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAITS = 2'd1,
        DATA  = 2'd2
    } dmem_state_t;

    // Core-internal MTIME/MTIMECMP registers; misses here are expected traffic.
    localparam logic [31:0] MTIME_LO = 32'hffff_8000;
    localparam logic [31:0] MTIME_HI = 32'hffff_800f;

    localparam int WAIT_MAX = 15;

endpackage

// File: rtl/rv_dmem_ram.sv
// Single-port word-organised SRAM with byte-lane write enables and a registered read port.
module rv_dmem_ram #(
    parameter int AWIDTH = 14
) (
    input  logic              clk,
    input  logic [AWIDTH-3:0] addr,
    input  logic              re,
    input  logic [3:0]        we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 2 ** (AWIDTH - 2);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/rv_dmem.sv
// Data-memory responder for the rv_core d_* bus: SRAM window, read wait states, miss logging.
// Optional miss counter/address capture is built only when RV_DMEM_ERRCNT_EN is defined.
//
// state | meaning
// IDLE  | ready, no read data pending, d_dr = 0
// WAITS | read accepted, counting wait states, d_rdy = 0
// DATA  | read word on d_dr, ready for the next request
module rv_dmem
    import pkg_rv_dmem::*;
#(
    parameter int          AWIDTH     = 14,
    parameter logic [31:0] BASE       = 32'h0000_0000,
    parameter int          WAIT       = 0,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        xreset,
    input  logic [31:0] d_adr,
    input  logic        d_re,
    input  logic [31:0] d_dw,
    input  logic [3:0]  d_we,
    output logic [31:0] d_dr,
    output logic        d_rdy,
    output logic        d_be,
    output logic [15:0] err_cnt,
    output logic [31:0] err_adr
);

    if (WAIT < 0 || WAIT > WAIT_MAX) begin : g_wait_range
        $error("rv_dmem: WAIT must be within 0..15");
    end

    localparam logic [3:0] WAIT_LD = 4'((WAIT == 0) ? 0 : WAIT - 1);

    dmem_state_t state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        hit, hit_q, wr_any, rd_acc;
    logic [31:0] ram_q;
    logic        unused_adr;

    assign unused_adr = ^d_adr[1:0];
    assign hit        = (d_adr[31:AWIDTH] == BASE[31:AWIDTH]);
    assign wr_any     = |d_we;
    // A request carrying write lanes is a write even if d_re is also set.
    assign rd_acc     = d_rdy & d_re & ~wr_any;

    assign d_rdy = (state != WAITS);
    assign d_dr  = (state == DATA && hit_q) ? ram_q : 32'h0;
    assign d_be  = BIG_ENDIAN;

    rv_dmem_ram #(.AWIDTH(AWIDTH)) u_ram (
        .clk   (clk),
        .addr  (d_adr[AWIDTH-1:2]),
        .re    (rd_acc & hit),
        .we    ((d_rdy & hit) ? d_we : 4'b0000),
        .wdata (d_dw),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            hit_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (rd_acc) begin
                hit_q <= hit;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, DATA: begin
                state_nxt = IDLE;
                if (rd_acc) begin
                    if (WAIT == 0) begin
                        state_nxt = DATA;
                    end else begin
                        state_nxt = WAITS;
                        cnt_nxt   = WAIT_LD;
                    end
                end
            end
            WAITS: begin
                if (cnt == 4'd0) begin
                    state_nxt = DATA;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

`ifdef RV_DMEM_ERRCNT_EN
    logic acc, in_timer, err_inc;

    assign acc      = d_rdy & (d_re | wr_any);
    assign in_timer = (d_adr >= MTIME_LO) && (d_adr <= MTIME_HI);
    assign err_inc  = acc & ~hit & ~in_timer;

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            err_cnt <= 16'h0;
            err_adr <= 32'h0;
        end else if (err_inc) begin
            if (err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'h1;
            end
            err_adr <= d_adr;
        end
    end
`else
    assign err_cnt = 16'h0;
    assign err_adr = 32'h0;
`endif

endmodule
